// File: rtl/vga_mode_ctrl_if.sv
// ---------------------------------------------------------------------------
// vga_mode_ctrl_if
// Bundle of the raster and display-mode signals exchanged between the VGA
// scan/mode sequencer and the rest of the video path.
//
// Signals:
//   mode_req      requested mode (0 text, 1 game), level, from the game FSM
//   x, y          current pixel column / line counters
//   hsync, vsync  active-low sync pulses
//   video_on      high inside the visible area
//   pix_tick      one-cycle pulse, counters advance on this edge
//   vblank_start  one-cycle pulse on the edge entering the first blank line
//   mode          select into the colour mux
//   mute          colour must be forced black while high
//   busy          a mode switch is pending or the mute window is running
//
// Modports:
//   master  the sequencer (drives raster and mode, samples mode_req)
//   slave   the consumer (drives mode_req, samples everything else)
// ---------------------------------------------------------------------------
interface vga_mode_ctrl_if;
   logic       mode_req;
   logic [9:0] x;
   logic [9:0] y;
   logic       hsync;
   logic       vsync;
   logic       video_on;
   logic       pix_tick;
   logic       vblank_start;
   logic       mode;
   logic       mute;
   logic       busy;

   modport master (
      input  mode_req,
      output x, y, hsync, vsync, video_on, pix_tick, vblank_start,
      output mode, mute, busy
   );

   modport slave (
      output mode_req,
      input  x, y, hsync, vsync, video_on, pix_tick, vblank_start,
      input  mode, mute, busy
   );
endinterface

// File: rtl/vga_mode_ctrl.sv
// ---------------------------------------------------------------------------
// vga_mode_ctrl
// Scan-timing and display-mode sequencer for the VGA output path. Generates
// the raster (pixel divider, h/v counters, sync and visible-area decodes) and
// owns the colour-mux mode select. Mode changes requested by the game FSM are
// deferred to the start of vertical blanking so a switch never tears a frame.
//
// Optional feature macro: VGA_MODE_CTRL_MUTE_EN
//   defined   : after each switch, mute stays high for BLANK_FRAMES whole
//               frames (MUTE state and frame counter present)
//   undefined : mute is tied low, the switch returns straight to IDLE and
//               BLANK_FRAMES has no effect
//
// Ports:
//   clk   system clock
//   rst   synchronous, active-high reset
//   bus   vga_mode_ctrl_if.master (mode_req in; x, y, hsync, vsync, video_on,
//         pix_tick, vblank_start, mode, mute, busy out)
// ---------------------------------------------------------------------------
module vga_mode_ctrl #(
   parameter int CLK_DIV      = 4,
   parameter int H_VISIBLE    = 640,
   parameter int H_FRONT      = 16,
   parameter int H_SYNC       = 96,
   parameter int H_BACK       = 48,
   parameter int V_VISIBLE    = 480,
   parameter int V_FRONT      = 10,
   parameter int V_SYNC       = 2,
   parameter int V_BACK       = 33,
   parameter int BLANK_FRAMES = 2
) (
   input  logic                   clk,
   input  logic                   rst,
   vga_mode_ctrl_if.master        bus
);

   localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
   localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;
   localparam int DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

   localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
   localparam logic [9:0] H_LAST   = 10'(H_TOTAL - 1);
   localparam logic [9:0] V_LAST   = 10'(V_TOTAL - 1);
   localparam logic [9:0] H_VIS    = 10'(H_VISIBLE);
   localparam logic [9:0] V_VIS    = 10'(V_VISIBLE);
   localparam logic [9:0] V_VIS_M1 = 10'(V_VISIBLE - 1);
   localparam logic [9:0] HS_BEG   = 10'(H_VISIBLE + H_FRONT);
   localparam logic [9:0] HS_END   = 10'(H_VISIBLE + H_FRONT + H_SYNC);
   localparam logic [9:0] VS_BEG   = 10'(V_VISIBLE + V_FRONT);
   localparam logic [9:0] VS_END   = 10'(V_VISIBLE + V_FRONT + V_SYNC);

   // Elaboration-time parameter sanity checks.
   if (CLK_DIV < 1) begin : g_bad_clk_div
      $error("vga_mode_ctrl: CLK_DIV must be at least 1");
   end
   if (BLANK_FRAMES < 0 || BLANK_FRAMES > 15) begin : g_bad_blank_frames
      $error("vga_mode_ctrl: BLANK_FRAMES must be in 0..15");
   end
   if (H_TOTAL > 1024 || V_TOTAL > 1024) begin : g_bad_totals
      $error("vga_mode_ctrl: raster totals must fit 10-bit counters");
   end

   // ------------------------------------------------------------------------
   // Raster counters
   // ------------------------------------------------------------------------
   logic [DIV_W-1:0] div;
   logic [9:0]       h;
   logic [9:0]       v;
   logic             pix_tick;
   logic             vblank_start;

   assign pix_tick     = (div == DIV_LAST);
   assign vblank_start = pix_tick && (h == H_LAST) && (v == V_VIS_M1);

   always_ff @(posedge clk) begin
      if (rst) begin
         div <= '0;
         h   <= '0;
         v   <= '0;
      end else begin
         if (pix_tick) begin
            div <= '0;
            if (h == H_LAST) begin
               h <= '0;
               v <= (v == V_LAST) ? 10'd0 : v + 10'd1;
            end else begin
               h <= h + 10'd1;
            end
         end else begin
            div <= div + DIV_W'(1);
         end
      end
   end

   assign bus.x            = h;
   assign bus.y            = v;
   assign bus.pix_tick     = pix_tick;
   assign bus.vblank_start = vblank_start;
   assign bus.hsync        = !((h >= HS_BEG) && (h < HS_END));
   assign bus.vsync        = !((v >= VS_BEG) && (v < VS_END));
   assign bus.video_on     = (h < H_VIS) && (v < V_VIS);

   // ------------------------------------------------------------------------
   // Mode FSM
   // ------------------------------------------------------------------------
`ifdef VGA_MODE_CTRL_MUTE_EN
   typedef enum logic [1:0] {IDLE = 2'd0, PEND = 2'd1, MUTE = 2'd2} state_t;
   localparam logic [3:0] BF_LAST = 4'(BLANK_FRAMES);
   logic [3:0] cnt, cnt_nxt;
   logic       mute_r, mute_nxt;
`else
   typedef enum logic {IDLE = 1'b0, PEND = 1'b1} state_t;
`endif

   state_t state, state_nxt;
   logic   mode_r, mode_nxt;

   always_ff @(posedge clk) begin
      if (rst) begin
         state  <= IDLE;
         mode_r <= 1'b0;
`ifdef VGA_MODE_CTRL_MUTE_EN
         mute_r <= 1'b0;
         cnt    <= '0;
`endif
      end else begin
         state  <= state_nxt;
         mode_r <= mode_nxt;
`ifdef VGA_MODE_CTRL_MUTE_EN
         mute_r <= mute_nxt;
         cnt    <= cnt_nxt;
`endif
      end
   end

   always_comb begin
      state_nxt = state;
      mode_nxt  = mode_r;
`ifdef VGA_MODE_CTRL_MUTE_EN
      mute_nxt  = mute_r;
      cnt_nxt   = cnt;
`endif
      case (state)
         IDLE: begin
            if (bus.mode_req != mode_r) state_nxt = PEND;
         end
         PEND: begin
            // A request that went back to the current mode is simply dropped.
            if (bus.mode_req == mode_r) begin
               state_nxt = IDLE;
            end else if (vblank_start) begin
               mode_nxt = bus.mode_req;
`ifdef VGA_MODE_CTRL_MUTE_EN
               if (BLANK_FRAMES == 0) begin
                  state_nxt = IDLE;
               end else begin
                  mute_nxt  = 1'b1;
                  cnt_nxt   = '0;
                  state_nxt = MUTE;
               end
`else
               state_nxt = IDLE;
`endif
            end
         end
`ifdef VGA_MODE_CTRL_MUTE_EN
         MUTE: begin
            // mode_req is deliberately ignored here; IDLE re-evaluates it.
            if (vblank_start) begin
               cnt_nxt = cnt + 4'd1;
               if ((cnt + 4'd1) == BF_LAST) begin
                  mute_nxt  = 1'b0;
                  state_nxt = IDLE;
               end
            end
         end
`endif
         default: state_nxt = IDLE;
      endcase
   end

   assign bus.mode = mode_r;
   assign bus.busy = (state != IDLE);
`ifdef VGA_MODE_CTRL_MUTE_EN
   assign bus.mute = mute_r;
`else
   assign bus.mute = 1'b0;
`endif

endmodule

// File: tb/tb_vga_mode_ctrl.sv
// ---------------------------------------------------------------------------
// tb_vga_mode_ctrl
// Randomized bench for vga_mode_ctrl on a shrunken raster (16x11 pixels,
// CLK_DIV=2) so many frames fit in a short run. A reference model derives the
// raster position from the cycle count since reset and tracks the mode logic
// as a pending flag plus a count of muted frames left.
// ---------------------------------------------------------------------------
module tb_vga_mode_ctrl;
   localparam int CD  = 2;
   localparam int HV  = 8, HF = 2, HS = 3, HB = 3;
   localparam int VV  = 6, VF = 1, VS = 2, VB = 2;
   localparam int BF  = 2;
   localparam int HT  = HV + HF + HS + HB;
   localparam int VT  = VV + VF + VS + VB;
   localparam int N_CYC = 40000;

`ifdef VGA_MODE_CTRL_MUTE_EN
   localparam int EFF_BF = BF;
`else
   localparam int EFF_BF = 0;
`endif

   logic clk;
   logic rst;

   vga_mode_ctrl_if vif ();

   vga_mode_ctrl #(
      .CLK_DIV(CD), .H_VISIBLE(HV), .H_FRONT(HF), .H_SYNC(HS), .H_BACK(HB),
      .V_VISIBLE(VV), .V_FRONT(VF), .V_SYNC(VS), .V_BACK(VB),
      .BLANK_FRAMES(BF)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (vif.master)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fail   = 0;

   task automatic check_eq(input string tag, input logic [31:0] obs,
                           input logic [31:0] exp, input int cyc);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d (cycle %0d since reset)",
                  tag, obs, exp, cyc);
      end
   endtask

   // Reference model state
   int m_n;          // clk edges since reset released
   bit m_mode;
   bit m_pend;
   int m_mute_left;  // whole frames of mute still to go

   initial begin
      int px, mh, mv, mdiv;
      bit mtick, mvbs;
      rst = 1'b1;
      vif.mode_req = 1'b0;
      m_n = 0; m_mode = 0; m_pend = 0; m_mute_left = 0;
      @(posedge clk);

      for (int c = 0; c < N_CYC; c++) begin
         @(negedge clk);
         mdiv  = m_n % CD;
         px    = m_n / CD;
         mh    = px % HT;
         mv    = (px / HT) % VT;
         mtick = (mdiv == CD - 1);
         mvbs  = mtick && (mh == HT - 1) && (mv == VV - 1);

         check_eq("x",            32'(vif.x),            32'(mh), m_n);
         check_eq("y",            32'(vif.y),            32'(mv), m_n);
         check_eq("pix_tick",     32'(vif.pix_tick),     32'(mtick), m_n);
         check_eq("vblank_start", 32'(vif.vblank_start), 32'(mvbs), m_n);
         check_eq("hsync",        32'(vif.hsync),
                  32'(!(mh >= HV + HF && mh < HV + HF + HS)), m_n);
         check_eq("vsync",        32'(vif.vsync),
                  32'(!(mv >= VV + VF && mv < VV + VF + VS)), m_n);
         check_eq("video_on",     32'(vif.video_on),
                  32'(mh < HV && mv < VV), m_n);
         check_eq("mode",         32'(vif.mode),         32'(m_mode), m_n);
         check_eq("mute",         32'(vif.mute),         32'(m_mute_left > 0), m_n);
         check_eq("busy",         32'(vif.busy),
                  32'(m_pend || m_mute_left > 0), m_n);

         // New inputs, sampled on the coming edge
         rst = (c == 0) ? 1'b0 : ($urandom_range(0, 9999) == 0);
         if ($urandom_range(0, 199) == 0) vif.mode_req = ~vif.mode_req;

         // Advance the model across that edge
         if (rst) begin
            m_n = 0; m_mode = 0; m_pend = 0; m_mute_left = 0;
         end else begin
            if (m_mute_left > 0) begin
               if (mvbs) m_mute_left--;
            end else if (m_pend) begin
               if (vif.mode_req == m_mode) begin
                  m_pend = 0;
               end else if (mvbs) begin
                  m_mode      = vif.mode_req;
                  m_pend      = 0;
                  m_mute_left = EFF_BF;
               end
            end else if (vif.mode_req != m_mode) begin
               m_pend = 1;
            end
            m_n++;
         end
      end

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_checks, n_fail);
      $finish;
   end
endmodule
